// File: rtl/game_pkg.sv
// Shared definitions for the game-flow sequencer: state codes, PS/2 key bytes and a
// width helper.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } game_state_e;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  // Bits needed to hold 0..value-1 (minimum 1).
  function automatic int unsigned logb2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Move-step divider: counts 0..period-1 while not held and emits a registered one-cycle
// tick on wrap.
module step_timer #(
  parameter int unsigned Width = 11
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             hold,
  input  logic             clear,
  input  logic [Width:0]   period,
  output logic             tick
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             hit;

  always_comb begin
    // >= so a shortened period after a level-up wraps on the very next compare
    hit    = ({1'b0, cnt_q} >= (period - {{Width{1'b0}}, 1'b1}));
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (hit) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + Width'(1);
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: PS/2 start/pause decode, IDLE/CLEAR/RUN/PAUSE/OVER FSM, score and
// speed-level tracking, and the level-dependent move-step divider.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned BASE_RATE       = 5,
  parameter int unsigned MAX_LEVEL       = 7,
  parameter int unsigned COINS_PER_LEVEL = 4,
  parameter int unsigned CLEAR_CYCLES    = 2048
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       coin_eaten,
  input  logic       game_over,
  output logic       game_clear,
  output logic       step,
  output logic [2:0] state,
  output logic [2:0] level,
  output logic [9:0] score,
  output logic       dim
);

  localparam int unsigned BasePeriod = CLK_HZ / BASE_RATE;
  localparam int unsigned TmrW       = logb2(BasePeriod);
  localparam int unsigned PerW       = TmrW + 1;
  localparam int unsigned ClrW       = logb2(CLEAR_CYCLES) + 1;
  localparam int unsigned CoinW      = logb2(COINS_PER_LEVEL) + 1;

  localparam logic [PerW-1:0]  BasePer  = PerW'(BasePeriod);
  localparam logic [PerW-1:0]  PerDec   = PerW'(BasePeriod / 16);
  localparam logic [2:0]       MaxLevel = 3'(MAX_LEVEL);
  localparam logic [ClrW-1:0]  ClrLast  = ClrW'(CLEAR_CYCLES - 1);
  localparam logic [CoinW-1:0] CoinLast = CoinW'(COINS_PER_LEVEL - 1);

  game_state_e      state_q, state_d;
  logic             brk_q, brk_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [CoinW-1:0] coin_cnt_q, coin_cnt_d;
  logic [2:0]       level_q, level_d;
  logic [9:0]       score_q, score_d;

  logic             enter_key, p_key;
  logic             tmr_hold, tmr_clear, tmr_tick;
  logic [PerW-1:0]  period;

  // Key decode: the byte after a break prefix is the released key and is dropped.
  always_comb begin
    brk_d     = brk_q;
    enter_key = 1'b0;
    p_key     = 1'b0;
    if (key_valid) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (key_code == KEY_BRK) begin
        brk_d = 1'b1;
      end else if (key_code == KEY_ENTER) begin
        enter_key = 1'b1;
      end else if (key_code == KEY_P) begin
        p_key = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enter_key) state_d = StClear;
      StClear: if (clr_cnt_q == ClrLast) state_d = StRun;
      StRun: begin
        if (game_over)  state_d = StOver;
        else if (p_key) state_d = StPause;
      end
      StPause: begin
        if (p_key)          state_d = StRun;
        else if (enter_key) state_d = StClear;
      end
      StOver:  if (enter_key) state_d = StClear;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    score_d    = score_q;
    level_d    = level_q;
    coin_cnt_d = coin_cnt_q;
    clr_cnt_d  = (state_q == StClear) ? clr_cnt_q + ClrW'(1) : '0;
    if (state_d == StClear && state_q != StClear) begin
      score_d    = '0;
      level_d    = '0;
      coin_cnt_d = '0;
    end else if (state_q == StRun && coin_eaten) begin
      if (score_q != 10'd1023) score_d = score_q + 10'd1;
      if (coin_cnt_q == CoinLast) begin
        coin_cnt_d = '0;
        if (level_q < MaxLevel) level_d = level_q + 3'd1;
      end else begin
        coin_cnt_d = coin_cnt_q + CoinW'(1);
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      brk_q      <= 1'b0;
      clr_cnt_q  <= '0;
      coin_cnt_q <= '0;
      level_q    <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      brk_q      <= brk_d;
      clr_cnt_q  <= clr_cnt_d;
      coin_cnt_q <= coin_cnt_d;
      level_q    <= level_d;
      score_q    <= score_d;
    end
  end

  // Divider only advances in cycles that stay in RUN, so leaving RUN never emits a step.
  assign period    = BasePer - PerW'(level_q) * PerDec;
  assign tmr_hold  = !(state_q == StRun && state_d == StRun);
  assign tmr_clear = (state_d == StClear);

  step_timer #(
    .Width (TmrW)
  ) u_step_timer (
    .mclk   (mclk),
    .reset  (reset),
    .hold   (tmr_hold),
    .clear  (tmr_clear),
    .period (period),
    .tick   (tmr_tick)
  );

  assign step       = tmr_tick;
  assign state      = state_q;
  assign level      = level_q;
  assign score      = score_q;
  assign game_clear = (state_q == StClear);
  assign dim        = (state_q == StPause) || (state_q == StOver);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with shortened timing (period 1600, decrement 100,
// clear 8 cycles).
module tb_game_flow_ctrl;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       coin_eaten = 1'b0;
  logic       game_over = 1'b0;
  logic       game_clear, step, dim;
  logic [2:0] state, level;
  logic [9:0] score;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 mclk = ~mclk;

  game_flow_ctrl #(
    .CLK_HZ          (1600),
    .BASE_RATE       (1),
    .MAX_LEVEL       (7),
    .COINS_PER_LEVEL (4),
    .CLEAR_CYCLES    (8)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .coin_eaten (coin_eaten),
    .game_over  (game_over),
    .game_clear (game_clear),
    .step       (step),
    .state      (state),
    .level      (level),
    .score      (score),
    .dim        (dim)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one key byte for exactly one clock.
  task automatic send_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge mclk);
    key_valid = 1'b0;
  endtask

  // Negedges until step is seen high; -1 if not within max.
  task automatic wait_step(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge mclk);
      if (step === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int steps_seen;
    repeat (2) @(negedge mclk);
    check("rst_state", 32'(state), 0);
    check("rst_clear", 32'(game_clear), 0);
    check("rst_step", 32'(step), 0);
    check("rst_level", 32'(level), 0);
    check("rst_score", 32'(score), 0);
    check("rst_dim", 32'(dim), 0);
    reset = 1'b0;
    @(negedge mclk);

    send_key(8'h5A);
    check("enter_clear_state", 32'(state), 1);
    check("enter_clear_flag", 32'(game_clear), 1);
    repeat (7) @(negedge mclk);
    check("clear_last_cycle", 32'(game_clear), 1);
    @(negedge mclk);
    check("clear_to_run", 32'(state), 2);
    check("clear_flag_drop", 32'(game_clear), 0);

    wait_step(2000, n);
    check("first_step_delay", 32'(n), 1600);
    wait_step(2000, n);
    check("step_period_l0", 32'(n), 1600);

    // Divider now 0; a released P must be swallowed.
    send_key(8'hF0);
    check("step_one_cycle", 32'(step), 0);
    send_key(8'h4D);
    check("brk_discard", 32'(state), 2);
    repeat (498) @(negedge mclk);
    send_key(8'h4D);
    check("pause_state", 32'(state), 3);
    check("pause_dim", 32'(dim), 1);
    steps_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge mclk);
      if (step === 1'b1) steps_seen++;
    end
    check("pause_no_steps", 32'(steps_seen), 0);
    send_key(8'h4D);
    check("resume_state", 32'(state), 2);
    check("resume_dim", 32'(dim), 0);
    wait_step(2000, n);
    check("resume_step_delay", 32'(n), 1100);

    coin_eaten = 1'b1;
    repeat (4) @(negedge mclk);
    coin_eaten = 1'b0;
    check("coins4_score", 32'(score), 4);
    check("coins4_level", 32'(level), 1);
    wait_step(2000, n);
    check("l1_first_step", 32'(n), 1496);
    wait_step(2000, n);
    check("l1_period", 32'(n), 1500);

    coin_eaten = 1'b1;
    repeat (26) @(negedge mclk);
    coin_eaten = 1'b0;
    check("coins30_score", 32'(score), 30);
    check("coins30_level_sat", 32'(level), 7);
    wait_step(2000, n);
    wait_step(2000, n);
    check("l7_period", 32'(n), 900);

    coin_eaten = 1'b1;
    repeat (1070) @(negedge mclk);
    coin_eaten = 1'b0;
    check("coins1100_score_sat", 32'(score), 1023);
    check("coins1100_level", 32'(level), 7);

    // Resync to divider 0, then raise game_over in the cycle a step is due.
    wait_step(2000, n);
    repeat (899) @(negedge mclk);
    game_over = 1'b1;
    @(negedge mclk);
    game_over = 1'b0;
    check("over_no_step", 32'(step), 0);
    check("over_state", 32'(state), 4);
    check("over_dim", 32'(dim), 1);
    check("over_score_held", 32'(score), 1023);
    @(negedge mclk);
    check("over_no_late_step", 32'(step), 0);

    send_key(8'h5A);
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_level", 32'(level), 0);
    repeat (8) @(negedge mclk);
    check("restart_run", 32'(state), 2);

    coin_eaten = 1'b1;
    game_over  = 1'b1;
    @(negedge mclk);
    coin_eaten = 1'b0;
    game_over  = 1'b0;
    check("coin_with_over_state", 32'(state), 4);
    check("coin_with_over_score", 32'(score), 1);
    send_key(8'h4D);
    check("over_ignores_p", 32'(state), 4);

    send_key(8'h5A);
    check("clear_again", 32'(state), 1);
    repeat (2) @(negedge mclk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_clear", 32'(game_clear), 0);
    @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    send_key(8'h4D);
    check("idle_ignores_p", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Game-flow sequencer between the PS/2 receiver and the snake game datapath. Decodes start/pause keys from the raw scan-code stream, runs the IDLE/CLEAR/RUN/PAUSE/OVER state machine, and issues the board-clear and move-step strobes that drive `snake_game`. Tracks score and speed level, raising the step rate as coins are eaten. Replaces the free-running fixed-rate game tick at top level.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, mclk frequency.
- `BASE_RATE`, 5, steps/s at level 0; `BASE_PERIOD = CLK_HZ/BASE_RATE` cycles.
- `MAX_LEVEL`, 7, highest level (≤7, level is 3 bits).
- `COINS_PER_LEVEL`, 4, coins per level increment.
- `CLEAR_CYCLES`, 2048, length of the board-clear phase in cycles.

Ports:
- `mclk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `key_valid` in 1: one-cycle strobe, `key_code` valid.
- `key_code` in 8: PS/2 set-2 scan code byte.
- `coin_eaten` in 1: one-cycle strobe from game.
- `game_over` in 1: level from game.
- `game_clear` out 1: high during CLEAR.
- `step` out 1: one-cycle move-advance strobe.
- `state` out 3: current state code.
- `level` out 3: current speed level.
- `score` out 10: coins eaten, binary.
- `dim` out 1: high in PAUSE or OVER (VGA overlay dim).

## Operation
- Key decode: 0xF0 sets `brk`; the next `key_valid` byte is discarded and clears `brk`. 0xE0 ignored, `brk` untouched. Make codes only: ENTER = 0x5A, P = 0x4D; all others ignored.
- IDLE: ENTER -> CLEAR.
- CLEAR: on entry score, level, coin count and divider cleared; `game_clear`=1 for exactly CLEAR_CYCLES cycles, then RUN.
- RUN: divider counts 0..period−1, `period = BASE_PERIOD − level*(BASE_PERIOD/16)`; at period−1 `step` pulses and divider wraps to 0. P -> PAUSE. `game_over`=1 -> OVER.
- PAUSE: divider frozen (not reset). P -> RUN, resumes from frozen count. ENTER -> CLEAR.
- OVER: ENTER -> CLEAR. Score and level held for display.
- coin_eaten (RUN only): score +1, saturates at 1023; coin count +1; when it reaches COINS_PER_LEVEL it resets to 0 and level +1, saturating at MAX_LEVEL. Ignored outside RUN.
- Level change takes effect on the divider's next compare; if divider already ≥ new period−1, `step` fires next cycle and wraps.
- game_over ignored outside RUN.

## Timing
- Reset: state IDLE (0), all outputs 0, `brk`=0, divider 0.
- State codes: IDLE 0, CLEAR 1, RUN 2, PAUSE 3, OVER 4.
- All outputs registered or decoded from registered state; key at cycle n -> new `state` at n+1.
- `step` high exactly one cycle; never in cycle of RUN->PAUSE or RUN->OVER transition.
- Same-cycle priority in RUN: game_over > P key > step; coin_eaten in same cycle as game_over is still counted.
- First `step` after CLEAR occurs `period` cycles after entering RUN.
- Reset mid-CLEAR or mid-RUN returns to IDLE immediately; `game_clear` and `step` drop asynchronously.

## Structure
- Shared package `game_pkg`: state encodings, key codes (KEY_ENTER, KEY_P, KEY_BRK, KEY_EXT), `logb2` function.
- Sub-module `step_timer`: divider with `hold`, `clear`, `period` input and `tick` output; width `logb2(BASE_PERIOD)`.
- FSM, key decode, score/level counters in `game_flow_ctrl`.

## Test plan
Sim parameters: CLK_HZ=1600, BASE_RATE=1 (BASE_PERIOD 1600, decrement 100), CLEAR_CYCLES=8, COINS_PER_LEVEL=4.
- Reset, send 0x5A -> state 1, `game_clear` high 8 cycles, state 2; first `step` 1600 cycles later, then every 1600.
- In RUN send 0xF0,0x4D -> no change; send 0x4D at divider=500 -> PAUSE, `dim`=1, no steps; 0x4D again -> next `step` 1100 cycles later.
- 4 coin strobes -> score 4, level 1, period 1500; 30 coins -> level saturates 7 (period 900); 1100 coins -> score 1023.
- `game_over` and `step` due in same cycle -> no `step`, state 4, `dim`=1; then 0x5A -> CLEAR, score/level 0.
- Assert `reset` during CLEAR cycle 3 -> state 0, `game_clear` 0 immediately; 0x4D in IDLE -> no effect.
